// File: rtl/dmem_pkg.sv
// Shared types for the pipelined data memory: access sizes, sequencer states,
// response-pipeline entry and lane helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } dmem_size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dmem_state_e;

  localparam int MAX_DW  = 64;
  localparam int MAX_OFF = 3;

  // Sized for the widest build; narrower builds use the low bits.
  typedef struct packed {
    logic [MAX_DW-1:0]  rdata;
    logic [MAX_OFF-1:0] offset;
    dmem_size_e         size;
    logic               sign_ext;
    logic               err;
    logic               is_load;
    logic               valid;
  } dmem_rsp_t;

  function automatic logic [7:0] lane_mask(input dmem_size_e sz);
    case (sz)
      SZ_BYTE: return 8'h01;
      SZ_HALF: return 8'h03;
      SZ_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input dmem_size_e sz);
    case (sz)
      SZ_BYTE: return 3'd0;
      SZ_HALF: return 3'd1;
      SZ_WORD: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select: shifts the addressed bytes down to bit 0 and sign- or
// zero-extends them to the full word width.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_BITS   = 2
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [OFF_BITS-1:0]   offset,
  input  dmem_size_e            size,
  input  logic                  sign_ext,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] sh, mask, top;
  int nb;

  always_comb begin
    nb   = 8 << size;
    sh   = word >> {offset, 3'b000};
    mask = (nb >= DATA_WIDTH) ? '1 : ~({DATA_WIDTH{1'b1}} << nb);
    // top isolates the sign bit of the selected lanes without a variable index
    top  = mask & ~(mask >> 1);
    data = sh & mask;
    if (sign_ext && |(sh & top)) data = data | ~mask;
  end

endmodule

// File: rtl/pipelined_data_memory.sv
// Single-port data memory with valid/ready requests, sub-word access, a
// READ_LATENCY-deep response pipeline and a post-reset zero-fill sequencer.
// Optional misalignment trapping is enabled by defining DMEM_ALIGN_CHECK_EN.
module pipelined_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int DEPTH    = 1 << ADDR_BITS;

  dmem_state_e          state;
  logic [ADDR_BITS-1:0] clr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else if (state == ST_INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) state <= ST_RUN;
    end
  end

  assign req_ready = (state == ST_RUN);
  assign init_done = (state == ST_RUN);

  dmem_size_e            sz;
  logic [OFF_BITS-1:0]   off_raw, amask, off;
  logic [ADDR_BITS-1:0]  widx;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] wdat;
  logic                  size_bad, err, fire, we;

  assign sz       = dmem_size_e'(req_size);
  assign off_raw  = req_addr[OFF_BITS-1:0];
  assign widx     = req_addr[ADDR_BITS+OFF_BITS-1:OFF_BITS];
  assign amask    = OFF_BITS'(align_mask(sz));
  assign size_bad = (DATA_WIDTH == 32) && (sz == SZ_DWORD);

`ifdef DMEM_ALIGN_CHECK_EN
  assign err = size_bad | (|(off_raw & amask));
  assign off = off_raw;
`else
  assign err = size_bad;
  assign off = off_raw & ~amask;
`endif

  assign fire = req_valid && req_ready;
  assign we   = fire && req_write && !err;
  assign be   = BYTES'(lane_mask(sz)) << off;
  assign wdat = req_wdata << {off, 3'b000};

  // No reset on the array: the INIT sequencer owns clearing it.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (state == ST_INIT) mem[clr_cnt] <= '0;
    else if (we) begin
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[widx][b*8 +: 8] <= wdat[b*8 +: 8];
    end
    if (fire && !req_write) ram_q <= mem[widx];
  end

  dmem_rsp_t req_meta, s1_full, tail;
  dmem_rsp_t pipe_q [READ_LATENCY];

  always_comb begin
    req_meta          = '0;
    req_meta.offset   = MAX_OFF'(off);
    req_meta.size     = sz;
    req_meta.sign_ext = req_signed;
    req_meta.err      = err;
    req_meta.is_load  = !req_write;
    req_meta.valid    = fire;
  end

  // Stage 1 metadata rides alongside the RAM output register.
  always_comb begin
    s1_full       = pipe_q[0];
    s1_full.rdata = MAX_DW'(ram_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= req_meta;
      for (int i = 1; i < READ_LATENCY; i++)
        pipe_q[i] <= (i == 1) ? s1_full : pipe_q[i-1];
    end
  end

  assign tail = (READ_LATENCY == 1) ? s1_full : pipe_q[READ_LATENCY-1];

  logic [DATA_WIDTH-1:0] aligned;

  dmem_load_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_BITS   (OFF_BITS)
  ) u_align (
    .word     (tail.rdata[DATA_WIDTH-1:0]),
    .offset   (tail.offset[OFF_BITS-1:0]),
    .size     (tail.size),
    .sign_ext (tail.sign_ext),
    .data     (aligned)
  );

  assign rsp_valid = tail.valid;
  assign rsp_err   = tail.valid & tail.err;
  assign rsp_rdata = (tail.valid && tail.is_load && !tail.err) ? aligned : '0;

  logic unused;
  assign unused = ^{tail, req_addr};

endmodule

// File: doc/pipelined_data_memory.md
# pipelined_data_memory

Parametrised single-port data memory for the pipelined CPU's MEM stage, replacing the fixed 256-word combinational-read RAM. It adds a valid/ready request port, sub-word loads and stores with sign or zero extension, a configurable registered read latency, and a hardware clear sequencer that zero-fills the array after reset so that no per-word reset logic is needed. Reads and writes share one port; every accepted request produces exactly one response.

## Interface
- ADDR_BITS, 8, word-address width; depth = 2^ADDR_BITS words
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64; BYTES = DATA_WIDTH/8
- READ_LATENCY, 1, cycles from request accept to response; legal range 1..4
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  log2 access bytes: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_WIDTH=64)
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned (bits [8*2^size-1:0] used)
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid; misaligned or illegal size
- init_done  out  1  clear sequence finished

## Operation
- States: INIT, RUN. reset_n low -> INIT, clear counter 0; all outputs 0.
- INIT: one word per cycle is written with zero at address counter, counter increments; after writing word 2^ADDR_BITS-1, move to RUN. req_ready = 0 throughout INIT.
- RUN: init_done = 1, req_ready = 1 every cycle; no backpressure from the response side.
- Word index = req_addr[ADDR_BITS+log2(BYTES)-1 : log2(BYTES)]; higher address bits are ignored (wrap-around).
- Byte offset = low log2(BYTES) bits. Store writes only the 2^size byte lanes starting at the offset; other lanes are unchanged.
- Load selects the same lanes, shifts to bit 0, and extends per req_signed.
- Illegal size (3 with DATA_WIDTH=32): no write, rsp_err = 1, rsp_rdata = 0.
- Store followed by load to the same word on the next accepted cycle returns the new data; no forwarding logic is needed because the write commits at the accepting edge.
- reset_n asserted at any point: the response pipeline is flushed (no rsp_valid for in-flight requests), and the sequencer restarts INIT from word 0.

## Timing
- Request accepted at edge N -> rsp_valid high in the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles later; back-to-back requests give back-to-back responses in order.
- Store data is visible in the array after edge N.
- After reset_n deasserts, init_done rises after exactly 2^ADDR_BITS rising edges.
- Array is synchronous-read RAM (block-RAM inferable); stage 1 is the RAM read, stages 2..READ_LATENCY are pipeline registers carrying rdata, offset, size, signed, err.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: an access whose offset is not a multiple of 2^size is flagged — no write, rsp_rdata = 0, rsp_err = 1.
- Undefined: offset low bits below the access size are forced to zero (access rounded down to natural alignment); rsp_err is driven only by illegal size.

## Structure
- Shared package dmem_pkg: access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD), FSM state enum, response-pipeline struct (rdata, offset, size, signed, err, valid).
- One sub-module: dmem_load_align (combinational lane select plus sign/zero extension), reused by the load-path stage of the CPU.

## Test plan
- Reset, ADDR_BITS=4: init_done low for 16 cycles, then high; load from each word -> 0x00000000, rsp_err 0.
- Store word 0xDEADBEEF to 0x08, then load signed byte at 0x0B -> 0xFFFFFFDE; unsigned half at 0x08 -> 0x0000BEEF.
- Store byte 0x5A to 0x0D over word 0x11223344 at 0x0C -> load word 0x0C returns 0x11225A44.
- READ_LATENCY=3, four consecutive loads -> four rsp_valid pulses in consecutive cycles starting 3 cycles after the first accept, in order.
- DMEM_ALIGN_CHECK_EN defined: store word to 0x06 -> rsp_err 1, word 0x04 unchanged; undefined: same store writes word 0x04.
- reset_n pulsed low with two loads in flight -> no rsp_valid afterwards, init_done low, sequencer restarts from word 0.
